// File: rtl/mult_pipe_hl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_hl_pkg
// Description : Shared types for the pipelined integer multiplier functional
//               unit: physical-register tag, branch mask and branch-stack
//               pointer widths, the multiply mode encoding, the per-stage
//               control struct and branch-mask helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pipe_hl_pkg;

  localparam int PHYS_REG_W = 6;
  localparam int B_MASK_W   = 4;
  localparam int BS_PTR_W   = $clog2(B_MASK_W);

  typedef logic [PHYS_REG_W-1:0] PHYS_REG;
  typedef logic [B_MASK_W-1:0]   B_MASK;
  typedef logic [BS_PTR_W-1:0]   BS_PTR;

  // MUL_LO   : low XLEN bits of the product
  // MUL_HIU  : high XLEN bits, operands treated as unsigned
  // MUL_LO32 : low 32 bits sign-extended to XLEN
  typedef enum logic [1:0] {
    MUL_LO   = 2'd0,
    MUL_HIU  = 2'd1,
    MUL_LO32 = 2'd2
  } MULT_MODE;

  // Control half of a pipeline stage. The arithmetic payload (accumulator,
  // remaining multiplier, shifted multiplicand) depends on XLEN and is
  // carried alongside this struct by the stage module.
  typedef struct packed {
    logic     valid;
    MULT_MODE mode;
    PHYS_REG  tag;
    B_MASK    bmask;
  } MULT_CTRL_t;

  // Drop the resolving branch's bit from a dependency mask.
  function automatic B_MASK bmask_clear(input B_MASK m, input logic resolved,
                                        input BS_PTR ptr);
    B_MASK r;
    r = m;
    if (resolved) r[ptr] = 1'b0;
    return r;
  endfunction

  // True when the entry depends on a branch resolving as mispredicted now.
  function automatic logic bmask_hit(input B_MASK m, input logic resolved,
                                     input logic wrong, input BS_PTR ptr);
    return resolved & wrong & m[ptr];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pstage.sv
`default_nettype none
// ============================================================================
// Module      : mult_pstage
// Description : One registered partial-product stage of the multiplier.
//               On load it captures the incoming entry after performing one
//               SHIFT-bit multiply-accumulate step; on hold it keeps its
//               payload and only applies branch clearing and squash.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               i_load            - stage captures its input this cycle
//               i_ctrl/i_acc/
//               i_mplier/i_mcand  - entry arriving from the previous stage
//               i_br_*            - branch resolution bus
//               o_ctrl            - stored control, valid squash-qualified and
//                                   bmask with the resolving bit cleared
//               o_acc/o_mplier/
//               o_mcand           - stored arithmetic payload
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pstage
  import mult_pipe_hl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int SHIFT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  MULT_CTRL_t        i_ctrl,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_mplier,
  input  logic [2*XLEN-1:0] i_mcand,
  input  logic              i_br_resolved,
  input  logic              i_br_wrong,
  input  BS_PTR             i_br_ptr,
  output MULT_CTRL_t        o_ctrl,
  output logic [2*XLEN-1:0] o_acc,
  output logic [XLEN-1:0]   o_mplier,
  output logic [2*XLEN-1:0] o_mcand
);

  localparam int PAD_W = 2*XLEN - SHIFT;

  MULT_CTRL_t        ctrl_q,   ctrl_d;
  logic [2*XLEN-1:0] acc_q,    acc_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] mcand_q,  mcand_d;

  logic              kill_q;
  logic              kill_in;
  logic [2*XLEN-1:0] digit_ext;

  assign kill_q  = bmask_hit(ctrl_q.bmask, i_br_resolved, i_br_wrong, i_br_ptr);
  assign kill_in = bmask_hit(i_ctrl.bmask, i_br_resolved, i_br_wrong, i_br_ptr);

  // The qualified view is what the ready chain, the next stage and the
  // output port all see, so a squashed entry never blocks the pipe.
  always_comb begin
    o_ctrl       = ctrl_q;
    o_ctrl.valid = ctrl_q.valid & ~kill_q;
    o_ctrl.bmask = bmask_clear(ctrl_q.bmask, i_br_resolved, i_br_ptr);
  end

  assign o_acc    = acc_q;
  assign o_mplier = mplier_q;
  assign o_mcand  = mcand_q;

  // Low SHIFT multiplier bits zero-extended so the product is 2*XLEN wide.
  assign digit_ext = {{PAD_W{1'b0}}, i_mplier[SHIFT-1:0]};

  always_comb begin
    ctrl_d   = o_ctrl;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    if (i_load) begin
      ctrl_d       = i_ctrl;
      ctrl_d.valid = i_ctrl.valid & ~kill_in;
      ctrl_d.bmask = bmask_clear(i_ctrl.bmask, i_br_resolved, i_br_ptr);
      acc_d        = i_acc + (digit_ext * i_mcand);
      mplier_d     = i_mplier >> SHIFT;
      mcand_d      = i_mcand << SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_pipe_hl.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_hl
// Description : Pipelined unsigned integer multiplier functional unit with
//               NUM_STAGE registered partial-product stages, bubble-collapsing
//               stall handling and per-entry branch-mask squash/clear.
// Ports       : clk, reset              - clock, async active-high reset
//               fus_en/opA/opB/mode/
//               tagDest/bmask           - issue request from FU select
//               fub_mult_busy           - FU buffer cannot accept result
//               br_branch_resolved/
//               br_pred_wrong/br_bs_ptr - branch resolution bus
//               mult_busy               - stage 0 cannot accept this cycle
//               mult_done/result/
//               tagDest/bmask           - completed result to FU buffer
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pipe_hl
  import mult_pipe_hl_pkg::*;
#(
  parameter int XLEN      = 64,   // must be >= 32 for MUL_LO32
  parameter int NUM_STAGE = 4     // must divide XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fus_en,
  input  logic [XLEN-1:0] fus_opA,
  input  logic [XLEN-1:0] fus_opB,
  input  MULT_MODE        fus_mode,
  input  PHYS_REG         fus_tagDest,
  input  B_MASK           fus_bmask,
  input  logic            fub_mult_busy,
  input  logic            br_branch_resolved,
  input  logic            br_pred_wrong,
  input  BS_PTR           br_bs_ptr,
  output logic            mult_busy,
  output logic            mult_done,
  output logic [XLEN-1:0] mult_result,
  output PHYS_REG         mult_tagDest,
  output B_MASK           mult_bmask
);

  localparam int SHIFT = XLEN / NUM_STAGE;
  localparam int LAST  = NUM_STAGE - 1;

  MULT_CTRL_t        stg_in_ctrl   [NUM_STAGE];
  logic [2*XLEN-1:0] stg_in_acc    [NUM_STAGE];
  logic [XLEN-1:0]   stg_in_mplier [NUM_STAGE];
  logic [2*XLEN-1:0] stg_in_mcand  [NUM_STAGE];

  MULT_CTRL_t        stg_ctrl      [NUM_STAGE];
  logic [2*XLEN-1:0] stg_acc       [NUM_STAGE];
  logic [XLEN-1:0]   stg_mplier    [NUM_STAGE];
  logic [2*XLEN-1:0] stg_mcand     [NUM_STAGE];

  // ready[k]: stage k may load this cycle. ready[NUM_STAGE] stands for the
  // FU buffer. A stage is ready when it holds nothing (empty or squashed
  // now) or its entry moves on, which is what lets bubbles collapse.
  logic [NUM_STAGE:0] ready;

  always_comb begin
    ready            = '0;
    ready[NUM_STAGE] = ~fub_mult_busy;
    for (int k = LAST; k >= 0; k--) begin
      ready[k] = ~stg_ctrl[k].valid | ready[k+1];
    end
  end

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stg_in_ctrl[k]   = '{valid: fus_en, mode: fus_mode,
                                  tag: fus_tagDest, bmask: fus_bmask};
      assign stg_in_acc[k]    = '0;
      assign stg_in_mplier[k] = fus_opB;
      assign stg_in_mcand[k]  = {{XLEN{1'b0}}, fus_opA};
    end else begin : g_body
      assign stg_in_ctrl[k]   = stg_ctrl[k-1];
      assign stg_in_acc[k]    = stg_acc[k-1];
      assign stg_in_mplier[k] = stg_mplier[k-1];
      assign stg_in_mcand[k]  = stg_mcand[k-1];
    end

    mult_pstage #(
      .XLEN  (XLEN),
      .SHIFT (SHIFT)
    ) u_pstage (
      .clk           (clk),
      .rst           (reset),
      .i_load        (ready[k]),
      .i_ctrl        (stg_in_ctrl[k]),
      .i_acc         (stg_in_acc[k]),
      .i_mplier      (stg_in_mplier[k]),
      .i_mcand       (stg_in_mcand[k]),
      .i_br_resolved (br_branch_resolved),
      .i_br_wrong    (br_pred_wrong),
      .i_br_ptr      (br_bs_ptr),
      .o_ctrl        (stg_ctrl[k]),
      .o_acc         (stg_acc[k]),
      .o_mplier      (stg_mplier[k]),
      .o_mcand       (stg_mcand[k])
    );
  end

  // The last stage's remaining multiplier and multiplicand are exhausted.
  logic unused_tail;
  assign unused_tail = ^{stg_mplier[LAST], stg_mcand[LAST]};

  assign mult_busy    = ~ready[0];
  assign mult_done    = stg_ctrl[LAST].valid;
  assign mult_tagDest = stg_ctrl[LAST].tag;
  assign mult_bmask   = stg_ctrl[LAST].bmask;

  always_comb begin
    mult_result = stg_acc[LAST][XLEN-1:0];
    case (stg_ctrl[LAST].mode)
      MUL_HIU:  mult_result = stg_acc[LAST][2*XLEN-1:XLEN];
      MUL_LO32: mult_result = {{(XLEN-32){stg_acc[LAST][31]}}, stg_acc[LAST][31:0]};
      default:  mult_result = stg_acc[LAST][XLEN-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_hl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_pipe_hl
// Description : Directed self-checking bench for mult_pipe_hl (XLEN=64,
//               NUM_STAGE=4): back-to-back issue, stall compaction, squash,
//               correct-predict bmask clearing and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_pipe_hl;
  import mult_pipe_hl_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            fus_en;
  logic [XLEN-1:0] fus_opA, fus_opB;
  MULT_MODE        fus_mode;
  PHYS_REG         fus_tagDest;
  B_MASK           fus_bmask;
  logic            fub_mult_busy;
  logic            br_branch_resolved, br_pred_wrong;
  BS_PTR           br_bs_ptr;
  logic            mult_busy, mult_done;
  logic [XLEN-1:0] mult_result;
  PHYS_REG         mult_tagDest;
  B_MASK           mult_bmask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_pipe_hl #(.XLEN(XLEN), .NUM_STAGE(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .fus_en             (fus_en),
    .fus_opA            (fus_opA),
    .fus_opB            (fus_opB),
    .fus_mode           (fus_mode),
    .fus_tagDest        (fus_tagDest),
    .fus_bmask          (fus_bmask),
    .fub_mult_busy      (fub_mult_busy),
    .br_branch_resolved (br_branch_resolved),
    .br_pred_wrong      (br_pred_wrong),
    .br_bs_ptr          (br_bs_ptr),
    .mult_busy          (mult_busy),
    .mult_done          (mult_done),
    .mult_result        (mult_result),
    .mult_tagDest       (mult_tagDest),
    .mult_bmask         (mult_bmask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    fus_en             = 1'b0;
    fus_opA            = '0;
    fus_opB            = '0;
    fus_mode           = MUL_LO;
    fus_tagDest        = '0;
    fus_bmask          = '0;
    br_branch_resolved = 1'b0;
    br_pred_wrong      = 1'b0;
    br_bs_ptr          = '0;
  endtask

  task automatic issue(input MULT_MODE m, input logic [63:0] a, input logic [63:0] b,
                       input PHYS_REG tag, input B_MASK bm);
    idle();
    fus_en      = 1'b1;
    fus_mode    = m;
    fus_opA     = a;
    fus_opB     = b;
    fus_tagDest = tag;
    fus_bmask   = bm;
  endtask

  task automatic resolve(input logic wrong, input BS_PTR ptr);
    br_branch_resolved = 1'b1;
    br_pred_wrong      = wrong;
    br_bs_ptr          = ptr;
  endtask

  initial begin
    reset         = 1'b1;
    fub_mult_busy = 1'b0;
    idle();
    settle();
    chk("rst_done", mult_done, 0);
    chk("rst_busy", mult_busy, 0);
    tick();
    tick();
    reset = 1'b0;

    // ---- back-to-back, no stall ----
    issue(MUL_LO, 64'd3, 64'd5, 6'd1, 4'b0000);
    settle(); chk("b2b_busy_c0", mult_busy, 0); tick();
    issue(MUL_HIU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd2, 4'b0000); tick();
    issue(MUL_LO32, 64'h8000_0000, 64'd1, 6'd3, 4'b0000); tick();
    idle();
    settle(); chk("b2b_done_c3", mult_done, 0); tick();
    settle(); chk("b2b_done_c4", mult_done, 1);
    chk("b2b_res_lo", mult_result, 64'd15); chk("b2b_tag_c4", mult_tagDest, 1); tick();
    settle(); chk("b2b_done_c5", mult_done, 1);
    chk("b2b_res_hiu", mult_result, 64'd1); chk("b2b_tag_c5", mult_tagDest, 2); tick();
    settle(); chk("b2b_done_c6", mult_done, 1);
    chk("b2b_res_lo32", mult_result, 64'hFFFF_FFFF_8000_0000);
    chk("b2b_tag_c6", mult_tagDest, 3); tick();
    settle(); chk("b2b_done_c7", mult_done, 0); tick();

    // ---- stall and compaction ----
    fub_mult_busy = 1'b1;
    issue(MUL_LO, 64'd7, 64'd6, 6'd4, 4'b0000);
    settle(); chk("stl_busy_c0", mult_busy, 0); tick();
    issue(MUL_LO, 64'd2, 64'd3, 6'd5, 4'b0000);
    settle(); chk("stl_busy_c1", mult_busy, 0); tick();
    issue(MUL_HIU, 64'h8000_0000_0000_0000, 64'd4, 6'd6, 4'b0000);
    settle(); chk("stl_busy_c2", mult_busy, 0); tick();
    issue(MUL_LO32, 64'hFFFF_FFFF, 64'd1, 6'd7, 4'b0000);
    settle(); chk("stl_busy_c3", mult_busy, 0); chk("stl_done_c3", mult_done, 0); tick();
    // Request while busy must be ignored.
    issue(MUL_LO, 64'd1, 64'd1, 6'd9, 4'b0000);
    settle(); chk("stl_busy_c4", mult_busy, 1); chk("stl_done_c4", mult_done, 1);
    chk("stl_tag_c4", mult_tagDest, 4); tick();
    idle();
    settle(); chk("stl_busy_c5", mult_busy, 1); chk("stl_res_c5", mult_result, 64'd42); tick();
    fub_mult_busy = 1'b0;
    settle(); chk("stl_done_c6", mult_done, 1); chk("stl_busy_c6", mult_busy, 0);
    chk("stl_res_a", mult_result, 64'd42); chk("stl_tag_a", mult_tagDest, 4); tick();
    settle(); chk("stl_done_c7", mult_done, 1);
    chk("stl_res_b", mult_result, 64'd6); chk("stl_tag_b", mult_tagDest, 5); tick();
    settle(); chk("stl_done_c8", mult_done, 1);
    chk("stl_res_c", mult_result, 64'd2); chk("stl_tag_c", mult_tagDest, 6); tick();
    settle(); chk("stl_done_c9", mult_done, 1);
    chk("stl_res_d", mult_result, 64'hFFFF_FFFF_FFFF_FFFF); chk("stl_tag_d", mult_tagDest, 7); tick();
    settle(); chk("stl_done_c10", mult_done, 0); tick();
    settle(); chk("stl_done_c11", mult_done, 0); tick();

    // ---- mispredict squash ----
    issue(MUL_LO, 64'd2, 64'd2, 6'd10, 4'b0001); tick();
    issue(MUL_LO, 64'd3, 64'd3, 6'd11, 4'b0010); tick();
    issue(MUL_LO, 64'd4, 64'd4, 6'd12, 4'b0001); tick();
    idle(); resolve(1'b1, 2'd0);
    settle(); chk("sq_done_c3", mult_done, 0); tick();
    idle();
    settle(); chk("sq_done_c4", mult_done, 0); tick();
    settle(); chk("sq_done_c5", mult_done, 1); chk("sq_res", mult_result, 64'd9);
    chk("sq_tag", mult_tagDest, 11); chk("sq_bmask", mult_bmask, 4'b0010); tick();
    settle(); chk("sq_done_c6", mult_done, 0); tick();
    settle(); chk("sq_done_c7", mult_done, 0); tick();

    // ---- correct predict: clear shown in the resolving cycle ----
    issue(MUL_LO, 64'd5, 64'd5, 6'd13, 4'b0011); tick();
    idle(); tick(); tick(); tick();
    resolve(1'b0, 2'd1);
    settle(); chk("cp_done", mult_done, 1); chk("cp_res", mult_result, 64'd25);
    chk("cp_bmask", mult_bmask, 4'b0001); tick();
    idle();

    // ---- resolution in the issue cycle ----
    issue(MUL_LO, 64'd6, 64'd7, 6'd14, 4'b0101); resolve(1'b0, 2'd2); tick();
    issue(MUL_LO, 64'd8, 64'd8, 6'd15, 4'b0100); resolve(1'b1, 2'd2); tick();
    idle(); tick(); tick();
    settle(); chk("ic_done_c4", mult_done, 1); chk("ic_tag", mult_tagDest, 14);
    chk("ic_res", mult_result, 64'd42); chk("ic_bmask", mult_bmask, 4'b0001); tick();
    settle(); chk("ic_done_c5", mult_done, 0); tick();

    // ---- mispredict in the cycle the buffer would accept ----
    issue(MUL_HIU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd16, 4'b1000); tick();
    idle(); tick(); tick(); tick();
    settle(); chk("la_done_pre", mult_done, 1); chk("la_res", mult_result, 64'hFFFF_FFFF_FFFF_FFFE);
    resolve(1'b1, 2'd3);
    #1; chk("la_done_kill", mult_done, 0); tick();
    idle();
    settle(); chk("la_done_after", mult_done, 0); tick();

    // ---- asynchronous reset mid-flight ----
    fub_mult_busy = 1'b1;
    issue(MUL_LO, 64'd1, 64'd1, 6'd20, 4'b0000); tick();
    issue(MUL_LO, 64'd1, 64'd1, 6'd21, 4'b0000); tick();
    issue(MUL_LO, 64'd1, 64'd1, 6'd22, 4'b0000); tick();
    issue(MUL_LO, 64'd1, 64'd1, 6'd23, 4'b0000); tick();
    idle();
    settle(); chk("ar_done_pre", mult_done, 1); chk("ar_busy_pre", mult_busy, 1);
    reset = 1'b1;
    #1; chk("ar_done_rst", mult_done, 0); chk("ar_busy_rst", mult_busy, 0);
    tick(); tick();
    settle();
    reset         = 1'b0;
    fub_mult_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      settle();
      chk("ar_done_post", mult_done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
